// File: rtl/dso_pkg.sv
// Shared types and sizing for the DSO capture path.
package dso_pkg;

  localparam int unsigned ADDR_W_DEF = 9;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POSTTRIG,
    DONE
  } cap_state_t;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/wrap_addr_ctr.sv
// Sample RAM write-address counter; wraps naturally modulo 2**ADDR_W.
module wrap_addr_ctr
  import dso_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (en) begin
      addr <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture-side controller: fills the pre-trigger ring, arms, writes the
// post-trigger samples and holds the finished trace until the host dumps it.
module capture_ctrl
  import dso_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_start,
  input  logic              en_sample,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              triggered,
  input  logic              dump_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              armed,
  output logic              set_capture_done,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trace_end
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  cap_state_t        state;
  logic [ADDR_W-1:0] tp_q;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   pre_target;
  logic              addr_clr;
  logic              tp_is_one;

  always_comb begin
    we = 1'b0;
    if (state == PRETRIG || state == ARMED || state == POSTTRIG) begin
      we = en_sample;
    end
  end

  always_comb begin
    cnt_inc    = cnt + 1'b1;
    pre_target = (ADDR_W+1)'(DEPTH) - {1'b0, tp_q};
    tp_is_one  = (tp_q == ADDR_W'(1));
    addr_clr   = (state == IDLE) && capture_start;
  end

  wrap_addr_ctr #(.ADDR_W(ADDR_W)) u_waddr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (addr_clr),
    .en    (we),
    .addr  (waddr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      tp_q             <= '0;
      cnt              <= '0;
      armed            <= 1'b0;
      set_capture_done <= 1'b0;
      capture_done     <= 1'b0;
      trace_end        <= '0;
    end else begin
      set_capture_done <= 1'b0;
      case (state)
        IDLE: begin
          if (capture_start) begin
            tp_q  <= (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
            cnt   <= '0;
            state <= PRETRIG;
          end
        end
        PRETRIG: begin
          if (we) begin
            cnt <= cnt_inc;
            if (cnt_inc == pre_target) begin
              armed <= 1'b1;
              state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (triggered) begin
            // The trigger-cycle write already counts as post sample 1, so a
            // single-sample trace completes straight from here.
            if (we && tp_is_one) begin
              trace_end        <= waddr;
              set_capture_done <= 1'b1;
              capture_done     <= 1'b1;
              armed            <= 1'b0;
              state            <= DONE;
            end else begin
              cnt   <= {{ADDR_W{1'b0}}, we};
              state <= POSTTRIG;
            end
          end
        end
        POSTTRIG: begin
          if (we) begin
            cnt <= cnt_inc;
            if (cnt_inc == {1'b0, tp_q}) begin
              trace_end        <= waddr;
              set_capture_done <= 1'b1;
              capture_done     <= 1'b1;
              armed            <= 1'b0;
              state            <= DONE;
            end
          end
        end
        DONE: begin
          if (dump_done) begin
            capture_done <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with ADDR_W=4; write addresses and trace
// ends are queued as stimulus is planned and popped as the DUT emits them.
module tb_capture_ctrl;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          capture_start = 1'b0;
  logic          en_sample = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic          triggered = 1'b0;
  logic          dump_done = 1'b0;
  logic          we;
  logic [AW-1:0] waddr;
  logic          armed;
  logic          set_capture_done;
  logic          capture_done;
  logic [AW-1:0] trace_end;

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int base = 0;
  int done_cyc = -1;
  logic prev_scd = 1'b0;

  logic [AW-1:0] aq[$];
  logic [AW-1:0] tq[$];

  capture_ctrl #(.ADDR_W(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .capture_start    (capture_start),
    .en_sample        (en_sample),
    .trig_pos         (trig_pos),
    .triggered        (triggered),
    .dump_done        (dump_done),
    .we               (we),
    .waddr            (waddr),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .capture_done     (capture_done),
    .trace_end        (trace_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [AW-1:0] e;
    @(negedge clk);
    if (we !== 1'b0) begin
      if (aq.size() == 0) begin
        chk("spurious_write", {31'd0, we}, 32'd0);
      end else begin
        e = aq.pop_front();
        chk("waddr", {28'd0, waddr}, {28'd0, e});
      end
    end
    @(posedge clk);
    #1;
    ncyc++;
    if (set_capture_done !== 1'b0) begin
      if (prev_scd) chk("scd_width", {31'd0, set_capture_done}, 32'd0);
      if (tq.size() == 0) begin
        chk("spurious_done", {31'd0, set_capture_done}, 32'd0);
      end else begin
        e = tq.pop_front();
        chk("trace_end", {28'd0, trace_end}, {28'd0, e});
        chk("cd_with_scd", {31'd0, capture_done}, 32'd1);
        chk("armed_clr", {31'd0, armed}, 32'd0);
        done_cyc = ncyc;
      end
    end
    prev_scd = set_capture_done;
  endtask

  task automatic start(input logic [AW-1:0] tp);
    trig_pos      = tp;
    capture_start = 1'b1;
    done_cyc      = -1;
    cyc();
    capture_start = 1'b0;
    base          = ncyc;
  endtask

  task automatic dump();
    dump_done = 1'b1;
    cyc();
    dump_done = 1'b0;
    chk("cd_cleared", {31'd0, capture_done}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, {31'd0, we}, 32'd0);
    chk({tag, "_waddr"}, {28'd0, waddr}, 32'd0);
    chk({tag, "_armed"}, {31'd0, armed}, 32'd0);
    chk({tag, "_scd"}, {31'd0, set_capture_done}, 32'd0);
    chk({tag, "_cd"}, {31'd0, capture_done}, 32'd0);
    chk({tag, "_tend"}, {28'd0, trace_end}, 32'd0);
  endtask

  initial begin
    // Reset state
    en_sample = 1'b1;
    cyc();
    cyc();
    chk_all_zero("reset");
    rst_n = 1'b1;
    cyc();

    // 1: basic capture, trigger at write 21
    for (int i = 0; i < 24; i++) aq.push_back(AW'(i));
    tq.push_back(AW'(7));
    start(AW'(4));
    for (int w = 1; w <= 24; w++) begin
      triggered = (w >= 21);
      cyc();
      if (w == 11) chk("s1_armed_pre", {31'd0, armed}, 32'd0);
      if (w == 12) chk("s1_armed_rise", {31'd0, armed}, 32'd1);
    end
    chk("s1_latency", done_cyc - base, 32'd24);
    chk("s1_waddr_end", {28'd0, waddr}, 32'd8);
    triggered = 1'b0;
    cyc();
    chk("s1_cd_hold", {31'd0, capture_done}, 32'd1);
    dump();
    chk("s1_queue_empty", aq.size(), 32'd0);

    // 2: trigger held high from start
    triggered = 1'b1;
    for (int i = 0; i < 16; i++) aq.push_back(AW'(i));
    tq.push_back(AW'(15));
    start(AW'(4));
    for (int w = 1; w <= 16; w++) begin
      cyc();
      if (w == 11) chk("s2_armed_pre", {31'd0, armed}, 32'd0);
      if (w == 12) chk("s2_armed_rise", {31'd0, armed}, 32'd1);
      if (w == 15) chk("s2_not_done", {31'd0, capture_done}, 32'd0);
    end
    chk("s2_latency", done_cyc - base, 32'd16);
    triggered = 1'b0;
    cyc();
    cyc();
    dump();
    chk("s2_queue_empty", aq.size(), 32'd0);

    // 3: trig_pos=0 behaves as 1; trigger lands on write 18 (third ARMED write)
    for (int i = 0; i < 18; i++) aq.push_back(AW'(i));
    tq.push_back(AW'(1));
    start(AW'(0));
    for (int w = 1; w <= 18; w++) begin
      triggered = (w == 18);
      cyc();
      if (w == 14) chk("s3_armed_pre", {31'd0, armed}, 32'd0);
      if (w == 15) chk("s3_armed_rise", {31'd0, armed}, 32'd1);
    end
    chk("s3_latency", done_cyc - base, 32'd18);
    triggered = 1'b0;
    dump();

    // 4: strobe high only on even cycles
    for (int i = 0; i < 24; i++) aq.push_back(AW'(i));
    tq.push_back(AW'(7));
    start(AW'(4));
    for (int k = 1; k <= 48; k++) begin
      en_sample = (k % 2 == 0);
      triggered = (k >= 42);
      cyc();
      if (k == 23) chk("s4_armed_pre", {31'd0, armed}, 32'd0);
      if (k == 24) chk("s4_armed_rise", {31'd0, armed}, 32'd1);
    end
    chk("s4_latency", done_cyc - base, 32'd48);
    en_sample = 1'b1;
    triggered = 1'b0;
    dump();

    // 5: commands outside their states are ignored
    for (int i = 0; i < 20; i++) aq.push_back(AW'(i));
    tq.push_back(AW'(3));
    start(AW'(4));
    for (int w = 1; w <= 20; w++) begin
      triggered     = (w >= 17);
      capture_start = (w == 18);
      trig_pos      = (w == 18) ? AW'(9) : AW'(4);
      cyc();
    end
    capture_start = 1'b0;
    triggered     = 1'b0;
    chk("s5_latency", done_cyc - base, 32'd20);
    capture_start = 1'b1;
    cyc();
    capture_start = 1'b0;
    cyc();
    chk("s5_cd_hold", {31'd0, capture_done}, 32'd1);
    chk("s5_waddr_hold", {28'd0, waddr}, 32'd4);
    dump();
    chk("s5_idle_waddr", {28'd0, waddr}, 32'd4);
    for (int i = 0; i < 14; i++) aq.push_back(AW'(i));
    start(AW'(4));
    chk("s5_restart_waddr", {28'd0, waddr}, 32'd0);

    // 6: reset while in POSTTRIG
    for (int w = 1; w <= 14; w++) begin
      triggered = (w >= 13);
      cyc();
    end
    chk("s6_armed_before", {31'd0, armed}, 32'd1);
    triggered = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("s6_rst");
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("s6_armed", {31'd0, armed}, 32'd0);
    chk("s6_cd", {31'd0, capture_done}, 32'd0);
    chk("s6_queue_empty", aq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
